// File: rtl/safe_combo_ctrl_pkg.sv
// Shared types and constants for the combination-safe controller.
package safe_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    // One BCD digit
    typedef logic [3:0] bcd_t;

    // Status outputs that depend only on the controller state
    typedef struct packed {
        logic actuate;
        logic open_cls;
        logic blank;
        logic lockout;
    } status_t;

    localparam int DEF_NDIG          = 3;
    localparam int DEF_MAXVAL        = 39;
    localparam int DEF_LOCKOUT_TRIES = 3;
    localparam int DEF_LOCKOUT_TICKS = 30000;

    // Status lamp / bolt / LCD pattern for a given state
    function automatic status_t status_for(state_t s);
        status_t r;
        r.actuate  = (s != ST_UNLOCKED);
        r.open_cls = (s == ST_UNLOCKED);
        r.blank    = (s == ST_LOCKOUT);
        r.lockout  = (s == ST_LOCKOUT);
        return r;
    endfunction

endpackage

// File: rtl/safe_combo_ctrl_if.sv
// Signal bundle between the encoder/keypad front end and the safe controller.
//
// Request inputs (cnten, dirch, lock, open) are single-cycle pulses sampled on
// the rising clock edge. There is no back-pressure: every pulse is either acted
// on or deliberately dropped in the cycle it arrives; up and doorCls are levels.
interface safe_combo_ctrl_if
    import safe_pkg::*;
#(
    parameter int NDIG = DEF_NDIG
);
    logic                      cnten;
    logic                      up;
    logic                      dirch;
    logic                      lock;
    logic                      open;
    logic                      doorCls;
    logic                      actuateLock;
    logic                      openCls;
    logic                      blank;
    logic                      lockout;
    logic                      err;
    logic [$clog2(NDIG+1)-1:0] sel;
    bcd_t                      bcd1;
    bcd_t                      bcd0;
    state_t                    dbg_state;

    modport slave (
        input  cnten, up, dirch, lock, open, doorCls,
        output actuateLock, openCls, blank, lockout, err, sel, bcd1, bcd0, dbg_state
    );

    modport master (
        output cnten, up, dirch, lock, open, doorCls,
        input  actuateLock, openCls, blank, lockout, err, sel, bcd1, bcd0, dbg_state
    );
endinterface

// File: rtl/safe_combo_ctrl_dial.sv
// BCD up/down dial counter, 0..MAXVAL with wrap in both directions.
module safe_dial
    import safe_pkg::*;
#(
    parameter int MAXVAL = DEF_MAXVAL
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_step,
    input  logic i_up,
    output bcd_t o_tens,
    output bcd_t o_units
);
    localparam bcd_t MAX_T = bcd_t'(MAXVAL / 10);
    localparam bcd_t MAX_U = bcd_t'(MAXVAL % 10);

    bcd_t r_tens;
    bcd_t r_units;
    logic w_at_max;
    logic w_at_zero;

    assign w_at_max  = (r_tens == MAX_T) && (r_units == MAX_U);
    assign w_at_zero = (r_tens == 4'd0) && (r_units == 4'd0);

    // Count one step per pulse; clear takes priority over a same-cycle step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tens  <= 4'd0;
            r_units <= 4'd0;
        end else if (i_clr) begin
            r_tens  <= 4'd0;
            r_units <= 4'd0;
        end else if (i_step) begin
            if (i_up) begin
                if (w_at_max) begin
                    r_tens  <= 4'd0;
                    r_units <= 4'd0;
                end else if (r_units == 4'd9) begin
                    r_units <= 4'd0;
                    r_tens  <= r_tens + 4'd1;
                end else begin
                    r_units <= r_units + 4'd1;
                end
            end else begin
                if (w_at_zero) begin
                    r_tens  <= MAX_T;
                    r_units <= MAX_U;
                end else if (r_units == 4'd0) begin
                    r_units <= 4'd9;
                    r_tens  <= r_tens - 4'd1;
                end else begin
                    r_units <= r_units - 4'd1;
                end
            end
        end
    end

    assign o_tens  = r_tens;
    assign o_units = r_units;
endmodule

// File: rtl/safe_combo_ctrl.sv
// N-digit combination safe: dial, digit capture, lock/open FSM and lockout timer.
module safe_combo_ctrl
    import safe_pkg::*;
#(
    parameter int NDIG          = DEF_NDIG,
    parameter int MAXVAL        = DEF_MAXVAL,
    parameter int LOCKOUT_TRIES = DEF_LOCKOUT_TRIES,
    parameter int LOCKOUT_TICKS = DEF_LOCKOUT_TICKS
) (
    input logic              clk,
    input logic              reset,
    safe_combo_ctrl_if.slave bus
);
    localparam int SELW  = $clog2(NDIG + 1);
    localparam int FAILW = $clog2(LOCKOUT_TRIES + 1);
    localparam int TIMW  = $clog2(LOCKOUT_TICKS + 1);

    state_t                 r_state;
    status_t                r_status;
    logic                   r_err;
    logic [SELW-1:0]        r_sel;
    logic [NDIG-1:0][7:0]   r_entry;
    logic [NDIG-1:0][7:0]   r_combo;
    logic [FAILW-1:0]       r_fails;
    logic [TIMW-1:0]        r_timer;

    bcd_t       w_tens;
    bcd_t       w_units;
    logic [7:0] w_dial;
    logic       w_full;
    logic       w_capture;
    logic       w_commit;
    logic       w_open_try;
    logic       w_dial_clr;
    logic       w_match;
    logic       w_fail_last;
    logic       w_timer_done;

    assign w_dial       = {w_tens, w_units};
    assign w_full       = (r_sel == SELW'(NDIG));
    assign w_capture    = bus.dirch && !w_full && (r_state != ST_LOCKOUT);
    // open outranks lock, so a commit needs lock without open in the same cycle
    assign w_commit     = (r_state == ST_UNLOCKED) && !bus.open && bus.lock && bus.doorCls && w_full;
    assign w_open_try   = (r_state == ST_LOCKED) && bus.open;
    assign w_dial_clr   = (r_state == ST_LOCKOUT) || w_commit || w_open_try;
    assign w_match      = w_full && (r_entry == r_combo);
    assign w_fail_last  = (r_fails == FAILW'(LOCKOUT_TRIES - 1));
    assign w_timer_done = (r_timer == TIMW'(LOCKOUT_TICKS - 1));

    safe_dial #(
        .MAXVAL (MAXVAL)
    ) u_dial (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_dial_clr),
        .i_step  (bus.cnten),
        .i_up    (bus.up),
        .o_tens  (w_tens),
        .o_units (w_units)
    );

    // Controller FSM: digit capture, requests, fail counting and lockout timing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_UNLOCKED;
            r_status <= status_for(ST_UNLOCKED);
            r_err    <= 1'b0;
            r_sel    <= '0;
            r_entry  <= '0;
            r_combo  <= '0;
            r_fails  <= '0;
            r_timer  <= '0;
        end else begin
            r_err <= 1'b0;
            // capture the dial as it was before any same-cycle step
            if (w_capture) begin
                r_entry[r_sel] <= w_dial;
                r_sel          <= r_sel + SELW'(1);
            end
            case (r_state)
                ST_UNLOCKED: begin
                    if (bus.open) begin
                        r_sel <= '0;
                    end else if (bus.lock) begin
                        if (w_commit) begin
                            r_combo  <= r_entry;
                            r_sel    <= '0;
                            r_state  <= ST_LOCKED;
                            r_status <= status_for(ST_LOCKED);
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (bus.open) begin
                        r_sel <= '0;
                        if (w_match) begin
                            r_fails  <= '0;
                            r_state  <= ST_UNLOCKED;
                            r_status <= status_for(ST_UNLOCKED);
                        end else begin
                            r_err   <= 1'b1;
                            r_fails <= r_fails + FAILW'(1);
                            if (w_fail_last) begin
                                r_timer  <= '0;
                                r_state  <= ST_LOCKOUT;
                                r_status <= status_for(ST_LOCKOUT);
                            end
                        end
                    end
                end
                ST_LOCKOUT: begin
                    r_sel <= '0;
                    if (w_timer_done) begin
                        r_fails  <= '0;
                        r_state  <= ST_LOCKED;
                        r_status <= status_for(ST_LOCKED);
                    end else begin
                        r_timer <= r_timer + TIMW'(1);
                    end
                end
                default: begin
                    r_state  <= ST_UNLOCKED;
                    r_status <= status_for(ST_UNLOCKED);
                end
            endcase
        end
    end

    assign bus.actuateLock = r_status.actuate;
    assign bus.openCls     = r_status.open_cls;
    assign bus.blank       = r_status.blank;
    assign bus.lockout     = r_status.lockout;
    assign bus.err         = r_err;
    assign bus.sel         = r_sel;
    assign bus.bcd1        = w_tens;
    assign bus.bcd0        = w_units;
    assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_safe_combo_ctrl.sv
// Self-checking bench for safe_combo_ctrl: vector table, directed sequences, random vs reference model.
module tb_safe_combo_ctrl;
    import safe_pkg::*;

    localparam int NDIG  = 3;
    localparam int MAXV  = 39;
    localparam int TRIES = 3;
    localparam int TICKS = 20;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    safe_combo_ctrl_if #(.NDIG(NDIG)) bus ();

    safe_combo_ctrl #(
        .NDIG          (NDIG),
        .MAXVAL        (MAXV),
        .LOCKOUT_TRIES (TRIES),
        .LOCKOUT_TICKS (TICKS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model (spec rules on plain ints) ----------------
    // m_state: 0 = unlocked, 1 = locked, 2 = lockout
    int m_state, m_dial, m_sel, m_fails, m_timer;
    int m_entry[NDIG];
    int m_combo[NDIG];
    bit m_err;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_dial = 0; m_sel = 0; m_fails = 0; m_timer = 0; m_err = 0;
        for (int i = 0; i < NDIG; i++) begin
            m_entry[i] = 0;
            m_combo[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_step(input bit c, input bit u, input bit d, input bit l, input bit o, input bit dc);
        int pre;
        int nsel;
        bit same;
        m_err = 0;
        if (m_state == 2) begin
            m_dial = 0;
            m_sel  = 0;
            m_timer++;
            if (m_timer == TICKS) begin
                m_state = 1;
                m_fails = 0;
            end
        end else begin
            pre  = m_dial;
            nsel = m_sel;
            if (d && m_sel < NDIG) begin
                m_entry[m_sel] = pre;
                nsel = m_sel + 1;
            end
            if (c) m_dial = u ? ((pre + 1) % (MAXV + 1)) : ((pre + MAXV) % (MAXV + 1));
            if (m_state == 0) begin
                if (o) nsel = 0;
                else if (l) begin
                    if (dc && m_sel == NDIG) begin
                        for (int i = 0; i < NDIG; i++) m_combo[i] = m_entry[i];
                        m_dial  = 0;
                        nsel    = 0;
                        m_state = 1;
                    end else m_err = 1;
                end
            end else if (o) begin
                same = (m_sel == NDIG);
                for (int i = 0; i < NDIG; i++) if (m_entry[i] != m_combo[i]) same = 0;
                if (same) begin
                    m_fails = 0;
                    m_state = 0;
                end else begin
                    m_err = 1;
                    m_fails++;
                    if (m_fails == TRIES) begin
                        m_state = 2;
                        m_timer = 0;
                    end
                end
                nsel   = 0;
                m_dial = 0;
            end
            m_sel = nsel;
        end
        exp_q.push_back({m_state != 0, m_state == 0, m_state == 2, m_state == 2,
                         m_err, 3'(m_sel), 8'(m_dial)});
    endtask

    // ---------------- driver ----------------
    task automatic apply(input bit c, input bit u, input bit d, input bit l, input bit o, input bit dc);
        logic [15:0] e;
        bus.cnten = c; bus.up = u; bus.dirch = d; bus.lock = l; bus.open = o; bus.doorCls = dc;
        model_step(c, u, d, l, o, dc);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("act",     int'(bus.actuateLock), int'(e[15]));
        check("opencls", int'(bus.openCls),     int'(e[14]));
        check("blank",   int'(bus.blank),       int'(e[13]));
        check("lockout", int'(bus.lockout),     int'(e[12]));
        check("err",     int'(bus.err),         int'(e[11]));
        check("sel",     int'(bus.sel),         int'(e[10:8]));
        check("bcd1",    int'(bus.bcd1),        int'(e[7:0]) / 10);
        check("bcd0",    int'(bus.bcd0),        int'(e[7:0]) % 10);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.cnten = 0; bus.up = 0; bus.dirch = 0; bus.lock = 0; bus.open = 0; bus.doorCls = 1;
        model_reset();
        #1;
        check("rst_act",     int'(bus.actuateLock), 0);
        check("rst_opencls", int'(bus.openCls),     1);
        check("rst_blank",   int'(bus.blank),       0);
        check("rst_lockout", int'(bus.lockout),     0);
        check("rst_err",     int'(bus.err),         0);
        check("rst_sel",     int'(bus.sel),         0);
        check("rst_dial",    int'(bus.bcd1) * 10 + int'(bus.bcd0), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic dial_to(input int t);
        for (int k = 0; k <= MAXV && m_dial != t; k++) apply(1, 1, 0, 0, 0, 1);
    endtask

    task automatic enter_code(input int a, input int b, input int c);
        dial_to(a); apply(0, 0, 1, 0, 0, 1);
        dial_to(b); apply(0, 0, 1, 0, 0, 1);
        dial_to(c); apply(0, 0, 1, 0, 0, 1);
    endtask

    function automatic int dial_now();
        return int'(bus.bcd1) * 10 + int'(bus.bcd0);
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        bit c, u, d, l, o, dc;
        bit act, ocl, err;
        int sel, dial;
    } vec_t;
    vec_t tbl[21];

    initial begin
        // c  u  d  l  o dc | act ocl err sel dial
        tbl[0]  = '{1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1};
        tbl[1]  = '{1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 2};
        tbl[2]  = '{0, 0, 1, 0, 0, 1, 0, 1, 0, 1, 2};
        tbl[3]  = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 2, 1};
        tbl[4]  = '{0, 0, 0, 1, 0, 1, 0, 1, 1, 2, 1};
        tbl[5]  = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 3, 0};
        tbl[6]  = '{0, 0, 0, 1, 0, 0, 0, 1, 1, 3, 0};
        tbl[7]  = '{0, 0, 1, 0, 0, 1, 0, 1, 0, 3, 0};
        tbl[8]  = '{0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0};
        tbl[10] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 39};
        tbl[11] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 39};
        tbl[12] = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0};
        tbl[13] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1};
        tbl[14] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 2};
        tbl[15] = '{0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 2};
        tbl[16] = '{0, 0, 1, 0, 0, 1, 1, 0, 0, 2, 2};
        tbl[17] = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 2, 1};
        tbl[18] = '{0, 0, 1, 0, 0, 1, 1, 0, 0, 3, 1};
        tbl[19] = '{0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0};
        tbl[20] = '{0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0};
    end

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        bit rc, ru, rd, rl, ro, rdc;
        int ca, cb, cc;

        do_reset();

        // Dial wrap: 40 up-steps from 0, then one down-step from 0
        repeat (MAXV) apply(1, 1, 0, 0, 0, 1);
        check("wrap_39_bcd1", int'(bus.bcd1), 3);
        check("wrap_39_bcd0", int'(bus.bcd0), 9);
        apply(1, 1, 0, 0, 0, 1);
        check("wrap_up_0", dial_now(), 0);
        apply(1, 0, 0, 0, 0, 1);
        check("wrap_dn_39", dial_now(), 39);

        // Vector table from a fresh reset
        do_reset();
        for (int i = 0; i < 21; i++) begin
            apply(tbl[i].c, tbl[i].u, tbl[i].d, tbl[i].l, tbl[i].o, tbl[i].dc);
            check($sformatf("tbl%0d_act", i),  int'(bus.actuateLock), int'(tbl[i].act));
            check($sformatf("tbl%0d_ocl", i),  int'(bus.openCls),     int'(tbl[i].ocl));
            check($sformatf("tbl%0d_err", i),  int'(bus.err),         int'(tbl[i].err));
            check($sformatf("tbl%0d_sel", i),  int'(bus.sel),         tbl[i].sel);
            check($sformatf("tbl%0d_dial", i), dial_now(),            tbl[i].dial);
        end

        // Lock with 12,05,33
        do_reset();
        enter_code(12, 5, 33);
        check("code_sel_full", int'(bus.sel), 3);
        apply(0, 0, 0, 1, 0, 1);
        check("lock_act", int'(bus.actuateLock), 1);
        check("lock_ocl", int'(bus.openCls), 0);
        check("lock_sel", int'(bus.sel), 0);
        check("lock_dial", dial_now(), 0);

        // Correct code opens
        enter_code(12, 5, 33);
        apply(0, 0, 0, 0, 1, 1);
        check("open_act", int'(bus.actuateLock), 0);
        check("open_ocl", int'(bus.openCls), 1);
        check("open_err", int'(bus.err), 0);

        // Relock, then two failed opens
        enter_code(12, 5, 33);
        apply(0, 0, 0, 1, 0, 1);
        check("relock_act", int'(bus.actuateLock), 1);
        enter_code(12, 5, 34);
        apply(0, 0, 0, 0, 1, 1);
        check("bad1_err", int'(bus.err), 1);
        check("bad1_act", int'(bus.actuateLock), 1);
        apply(0, 0, 0, 0, 0, 1);
        check("bad1_err_pulse", int'(bus.err), 0);
        apply(0, 0, 1, 0, 0, 1);
        apply(0, 0, 0, 0, 1, 1);
        check("bad2_err", int'(bus.err), 1);
        check("bad2_lockout", int'(bus.lockout), 0);

        // Third failure -> lockout for exactly TICKS cycles, pulses ignored
        apply(0, 0, 0, 0, 1, 1);
        check("bad3_err", int'(bus.err), 1);
        check("bad3_blank", int'(bus.blank), 1);
        check("bad3_lockout", int'(bus.lockout), 1);
        for (int i = 0; i < TICKS - 1; i++) begin
            apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
            check("lo_hold_lockout", int'(bus.lockout), 1);
            check("lo_hold_sel", int'(bus.sel), 0);
            check("lo_hold_dial", dial_now(), 0);
        end
        apply(1, 1, 1, 0, 0, 1);
        check("lo_end_lockout", int'(bus.lockout), 0);
        check("lo_end_blank", int'(bus.blank), 0);
        check("lo_end_act", int'(bus.actuateLock), 1);
        enter_code(12, 5, 33);
        apply(0, 0, 0, 0, 1, 1);
        check("lo_after_open", int'(bus.actuateLock), 0);

        // Same-cycle dirch + cnten at 07
        dial_to(7);
        apply(1, 1, 1, 0, 0, 1);
        check("same_cyc_sel", int'(bus.sel), 1);
        check("same_cyc_dial", dial_now(), 8);
        apply(0, 0, 0, 0, 1, 1);

        // Reset in the middle of a lockout
        enter_code(1, 2, 3);
        apply(0, 0, 0, 1, 0, 1);
        repeat (TRIES) apply(0, 0, 0, 0, 1, 1);
        repeat (5) apply(0, 0, 0, 0, 0, 1);
        check("pre_rst_lockout", int'(bus.lockout), 1);
        do_reset();
        apply(0, 0, 0, 0, 0, 1);

        // Directed-random sessions: random code, sometimes the right one on open
        for (int s = 0; s < 8; s++) begin
            ca = $urandom_range(0, MAXV); cb = $urandom_range(0, MAXV); cc = $urandom_range(0, MAXV);
            apply(0, 0, 0, 0, 1, 1);
            enter_code(ca, cb, cc);
            apply(0, 0, 0, 1, 0, 1);
            if ($urandom_range(0, 1) == 1) enter_code(ca, cb, cc);
            else enter_code(ca, cb, (cc + 1) % (MAXV + 1));
            apply(0, 0, 0, 0, 1, 1);
            repeat (TICKS + 2) apply(0, 0, 0, 0, 0, 1);
        end

        // Free random traffic
        for (int i = 0; i < 1500; i++) begin
            rc  = ($urandom_range(0, 99) < 50);
            ru  = ($urandom_range(0, 99) < 50);
            rd  = ($urandom_range(0, 99) < 15);
            rl  = ($urandom_range(0, 99) < 10);
            ro  = ($urandom_range(0, 99) < 6);
            rdc = ($urandom_range(0, 99) < 90);
            apply(rc, ru, rd, rl, ro, rdc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
